sa_nxn_os: RTL and testbench

- Parametrised N x N output-stationary systolic matrix-multiply engine with an integrated control FSM.
- Computes C = A x B for an N x K by K x N job. One A column and one B row stream in per accepted beat.
- Internal skew registers align the operands to the PE grid. The N*N results are emitted serially, row-major, over a valid/ready port.
- Successor to the fixed 2x2 array. Adds parametrised size and widths, input/output handshakes, variable K and per-job clear.

---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_pe.sv | 62 ++++++
 rtl/sa_nxn_os.sv | 190 +++++++++++++++++++
 tb/tb_sa_nxn_os.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the N x N output-stationary systolic engine.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        OUT
    } state_t;

    // Width of the serial result index for an n x n grid.
    function automatic int idx_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Cycles needed after the last beat for it to reach the far corner PE.
    function automatic int drain_cyc(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: forwards a right and b down through registers and
// accumulates a*b whenever both operands carry a valid tag.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic [DW-1:0] a_i,
    input  logic          av_i,
    input  logic [DW-1:0] b_i,
    input  logic          bv_i,
    output logic [DW-1:0] a_o,
    output logic          av_o,
    output logic [DW-1:0] b_o,
    output logic          bv_o,
    output logic [AW-1:0] acc_o
);

    logic [DW-1:0]   a_q, b_q;
    logic            av_q, bv_q;
    logic [AW-1:0]   acc_q, acc_d;
    logic [2*DW-1:0] prod;

    assign prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};

    // The size cast zero-extends or truncates the product; the sum wraps at AW bits.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (av_i && bv_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            av_q  <= 1'b0;
            bv_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            av_q  <= av_i;
            bv_q  <= bv_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign av_o  = av_q;
    assign b_o   = b_q;
    assign bv_o  = bv_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/sa_nxn_os.sv
// N x N output-stationary systolic matrix multiplier: skewed operand injection,
// PE grid, control FSM and a serial row-major result port.
module sa_nxn_os
    import sa_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 24,
    parameter int KW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DW-1:0]       a_vec,
    input  logic [N*DW-1:0]       b_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         out_data,
    output logic [idx_w(N)-1:0]   out_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int NN        = N * N;
    localparam int IW        = idx_w(N);
    localparam int DRAIN_CYC = drain_cyc(N);
    localparam int DCW       = $clog2(DRAIN_CYC + 1);

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [KW-1:0]  cnt_q, cnt_d;
    logic [DCW-1:0] drn_q, drn_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           done_q, done_d;
    logic           clr;
    logic           beat;

    logic [DW-1:0]  a_h  [N][N+1];
    logic           av_h [N][N+1];
    logic [DW-1:0]  b_v  [N+1][N];
    logic           bv_v [N+1][N];
    logic [AW-1:0]  acc_w [NN];

    assign in_ready  = (state_q == STREAM);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_idx   = idx_q;
    assign out_data  = out_valid ? acc_w[idx_q] : '0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    k_d     = k_len;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (k_len != '0) ? STREAM : OUT;
                end
            end
            STREAM: begin
                if (beat) begin
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_q + KW'(1) == k_q) begin
                        state_d = DRAIN;
                        drn_d   = '0;
                    end
                end
            end
            DRAIN: begin
                drn_d = drn_q + DCW'(1);
                if (drn_q == DCW'(DRAIN_CYC - 1)) begin
                    state_d = OUT;
                    idx_d   = '0;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (idx_q == IW'(NN - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Row i of A and column i of B are delayed i cycles so operand pairs of the
    // same beat meet in every PE; a non-accepted cycle injects a bubble tag.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            if (gi == 0) begin : g_direct
                assign a_h[0][0]  = a_vec[DW-1:0];
                assign av_h[0][0] = beat;
                assign b_v[0][0]  = b_vec[DW-1:0];
                assign bv_v[0][0] = beat;
            end else begin : g_delay
                logic [DW-1:0] a_dl_q  [gi];
                logic          av_dl_q [gi];
                logic [DW-1:0] b_dl_q  [gi];
                logic          bv_dl_q [gi];

                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int d = 0; d < gi; d++) begin
                            a_dl_q[d]  <= '0;
                            av_dl_q[d] <= 1'b0;
                            b_dl_q[d]  <= '0;
                            bv_dl_q[d] <= 1'b0;
                        end
                    end else begin
                        a_dl_q[0]  <= a_vec[gi*DW +: DW];
                        av_dl_q[0] <= beat;
                        b_dl_q[0]  <= b_vec[gi*DW +: DW];
                        bv_dl_q[0] <= beat;
                        for (int d = 1; d < gi; d++) begin
                            a_dl_q[d]  <= a_dl_q[d-1];
                            av_dl_q[d] <= av_dl_q[d-1];
                            b_dl_q[d]  <= b_dl_q[d-1];
                            bv_dl_q[d] <= bv_dl_q[d-1];
                        end
                    end
                end

                assign a_h[gi][0]  = a_dl_q[gi-1];
                assign av_h[gi][0] = av_dl_q[gi-1];
                assign b_v[0][gi]  = b_dl_q[gi-1];
                assign bv_v[0][gi] = bv_dl_q[gi-1];
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                sa_pe #(
                    .DW(DW),
                    .AW(AW)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .clr_i (clr),
                    .a_i   (a_h[gi][gj]),
                    .av_i  (av_h[gi][gj]),
                    .b_i   (b_v[gi][gj]),
                    .bv_i  (bv_v[gi][gj]),
                    .a_o   (a_h[gi][gj+1]),
                    .av_o  (av_h[gi][gj+1]),
                    .b_o   (b_v[gi+1][gj]),
                    .bv_o  (bv_v[gi+1][gj]),
                    .acc_o (acc_w[gi*N+gj])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_sa_nxn_os.sv
// Bench for sa_nxn_os: a 24-bit and a 16-bit accumulator instance share stimulus;
// table jobs carry hand-computed results, random jobs use a matrix-product model.
module tb_sa_nxn_os;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int KW = 8;
    localparam int NN = N * N;

    logic            clk = 1'b0;
    logic            rst, start, in_valid, out_ready;
    logic [KW-1:0]   k_len;
    logic [N*DW-1:0] a_vec, b_vec;

    logic            rdy24, ov24, busy24, done24;
    logic [23:0]     od24;
    logic [1:0]      oi24;
    logic            rdy16, ov16, busy16, done16;
    logic [15:0]     od16;
    logic [1:0]      oi16;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sa_nxn_os #(.N(N), .DW(DW), .AW(24), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(rdy24), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(ov24), .out_ready(out_ready), .out_data(od24), .out_idx(oi24),
        .busy(busy24), .done(done24)
    );

    sa_nxn_os #(.N(N), .DW(DW), .AW(16), .KW(KW)) dut16 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(rdy16), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .out_idx(oi16),
        .busy(busy16), .done(done16)
    );

    int     tests = 0;
    int     fails = 0;
    int     a_job [16][N];   // a_job[k][i] = A[i][k]
    int     b_job [16][N];   // b_job[k][j] = B[k][j]
    longint e24 [NN];
    longint e16 [NN];

    typedef struct packed {
        logic [7:0]       k;
        logic [7:0]       bub;
        logic [7:0]       st_idx;
        logic [7:0]       st_len;
        logic             poke;
        logic [3:0][7:0]  a;     // a[i*2+k] = A[i][k]
        logic [3:0][7:0]  b;     // b[k*2+j] = B[k][j]
        logic [3:0][23:0] x24;
        logic [3:0][15:0] x16;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // C = A x B by plain summation, reduced modulo each accumulator width.
    task automatic model(input int k);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(a_job[kk][i]) * longint'(b_job[kk][j]);
                e24[i*N+j] = s & 64'hFF_FFFF;
                e16[i*N+j] = s & 64'hFFFF;
            end
        end
    endtask

    task automatic do_job(input int k, input int bub, input bit rnd, input int st_idx,
                          input int st_len, input bit poke, input string tag);
        int  t0, lat, nidx, stalled, nb;
        bit  seen, fin, hs;
        start = 1'b1;
        k_len = k[KW-1:0];
        step();
        start = 1'b0;
        t0 = cyc;
        for (int kk = 0; kk < k; kk++) begin
            nb = rnd ? int'($urandom_range(0, 2)) : ((kk > 0) ? bub : 0);
            for (int b = 0; b < nb; b++) begin
                in_valid = 1'b0;
                a_vec = N*DW'($urandom);
                b_vec = N*DW'($urandom);
                step();
            end
            chk({tag, "_in_ready"}, rdy24, 1);
            chk({tag, "_in_ready16"}, rdy16, 1);
            chk({tag, "_early_valid"}, ov24, 0);
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                a_vec[i*DW +: DW] = a_job[kk][i][DW-1:0];
                b_vec[i*DW +: DW] = b_job[kk][i][DW-1:0];
            end
            step();
        end
        in_valid = 1'b0;
        nidx = 0; stalled = 0; seen = 0; fin = 0; lat = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            out_ready = 1'b1;
            start = 1'b0;
            if (ov24) begin
                if (!seen) begin
                    seen = 1;
                    lat = cyc - t0 + 1;
                    if (k > 0 && bub == 0 && !rnd) chk({tag, "_latency"}, lat, k + 2*N);
                    if (poke) begin
                        start = 1'b1;
                        k_len = 8'd5;
                    end
                end
                chk({tag, "_idx"}, oi24, nidx);
                chk({tag, "_data"}, od24, e24[nidx]);
                chk({tag, "_valid16"}, ov16, 1);
                chk({tag, "_idx16"}, oi16, nidx);
                chk({tag, "_data16"}, od16, e16[nidx]);
                chk({tag, "_in_ready_out"}, rdy24, 0);
                if (nidx == st_idx && stalled < st_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end
            end
            hs = ov24 && out_ready;
            step();
            if (hs) begin
                nidx++;
                if (nidx == NN) begin
                    fin = 1;
                    chk({tag, "_done"}, done24, 1);
                    chk({tag, "_done16"}, done16, 1);
                    chk({tag, "_valid_after"}, ov24, 0);
                    chk({tag, "_busy_after"}, busy24, 0);
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d results required %0d", tag, nidx, NN);
        end
        step();
        chk({tag, "_done_pulse"}, done24, 0);
        chk({tag, "_idle"}, busy24, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_vec = '0; b_vec = '0; out_ready = 1'b1;

        tbl[0] = '{k: 8'd2, bub: 8'd0, st_idx: 8'd0, st_len: 8'd0, poke: 1'b0,
                   a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
                   x24: {24'd50, 24'd43, 24'd22, 24'd19}, x16: {16'd50, 16'd43, 16'd22, 16'd19}};
        tbl[1] = tbl[0];
        tbl[1].bub = 8'd3;
        tbl[2] = tbl[0];
        tbl[2].st_idx = 8'd1;
        tbl[2].st_len = 8'd4;
        tbl[2].poke = 1'b1;
        tbl[3] = '{k: 8'd2, bub: 8'd0, st_idx: 8'd0, st_len: 8'd0, poke: 1'b0,
                   a: {4{8'd255}}, b: {4{8'd255}},
                   x24: {4{24'd130050}}, x16: {4{16'd64514}}};
        tbl[4] = '{k: 8'd0, bub: 8'd0, st_idx: 8'd0, st_len: 8'd0, poke: 1'b0,
                   a: '0, b: '0, x24: '0, x16: '0};

        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", rdy24, 0);
        chk("rst_out_valid", ov24, 0);
        chk("rst_out_data", od24, 0);
        chk("rst_out_idx", oi24, 0);
        chk("rst_busy", busy24, 0);
        chk("rst_done", done24, 0);

        for (int t = 0; t < 5; t++) begin
            for (int kk = 0; kk < 2; kk++) begin
                for (int i = 0; i < N; i++) begin
                    a_job[kk][i] = int'(tbl[t].a[i*2+kk]);
                    b_job[kk][i] = int'(tbl[t].b[kk*2+i]);
                end
            end
            for (int n = 0; n < NN; n++) begin
                e24[n] = longint'(tbl[t].x24[n]);
                e16[n] = longint'(tbl[t].x16[n]);
            end
            do_job(int'(tbl[t].k), int'(tbl[t].bub), 1'b0, int'(tbl[t].st_idx),
                   int'(tbl[t].st_len), tbl[t].poke, $sformatf("tbl%0d", t));
        end

        // Reset during STREAM after one accepted beat abandons the job.
        start = 1'b1;
        k_len = 8'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        a_vec = {8'd3, 8'd1};
        b_vec = {8'd6, 8'd5};
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", rdy24, 0);
        chk("midrst_out_valid", ov24, 0);
        chk("midrst_out_data", od24, 0);
        chk("midrst_out_idx", oi24, 0);
        chk("midrst_busy", busy24, 0);
        chk("midrst_busy16", busy16, 0);
        chk("midrst_done", done24, 0);
        a_job[0][0] = 1; a_job[0][1] = 3; b_job[0][0] = 5; b_job[0][1] = 6;
        a_job[1][0] = 2; a_job[1][1] = 4; b_job[1][0] = 7; b_job[1][1] = 8;
        e24[0] = 19; e24[1] = 22; e24[2] = 43; e24[3] = 50;
        for (int n = 0; n < NN; n++) e16[n] = e24[n];
        do_job(2, 0, 1'b0, 0, 0, 1'b0, "after_rst");

        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(1, 8));
            for (int kk = 0; kk < k; kk++) begin
                for (int i = 0; i < N; i++) begin
                    a_job[kk][i] = int'($urandom_range(0, 255));
                    b_job[kk][i] = int'($urandom_range(0, 255));
                end
            end
            model(k);
            do_job(k, 0, 1'b1, int'($urandom_range(0, NN-1)), int'($urandom_range(0, 3)),
                   1'b0, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
